// File: rtl/ntt_params_pkg.sv
// Shared NTT arithmetic parameters: residue width and the modulus table
// used by the modular adder, subtractor and multiplier.
package ntt_params_pkg;

    localparam int Q_WIDTH = 30;

    function automatic logic [Q_WIDTH-1:0] get_modulus(input int index);
        logic [Q_WIDTH-1:0] q;
        case (index)
            0:       q = 30'd1063321601;
            1:       q = 30'd1063452673;
            2:       q = 30'd1064697857;
            3:       q = 30'd1065484289;
            4:       q = 30'd1065811969;
            5:       q = 30'd1068236801;
            6:       q = 30'd1068433409;
            7:       q = 30'd1068564481;
            8:       q = 30'd1069219841;
            9:       q = 30'd1070727169;
            10:      q = 30'd1071513601;
            11:      q = 30'd1072496641;
            default: q = 30'd1073479681;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/modular_subtractor.sv
// Two-stage streaming c = (a - b) mod Q with valid/ready on both sides.
// Stage 1 holds the raw 31-bit difference, stage 2 the corrected residue.
module modular_subtractor
    import ntt_params_pkg::*;
#(
    parameter int MOD_INDEX = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Q_WIDTH-1:0] a,
    input  logic [Q_WIDTH-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Q_WIDTH-1:0] c,
    output logic               range_err,
    input  logic               clear_err
);

    localparam logic [Q_WIDTH-1:0] Q = get_modulus(MOD_INDEX);

    logic [2:1]         r_vld_pipe;
    logic [Q_WIDTH:0]   r_s1_diff;
    logic [Q_WIDTH-1:0] r_s2_c;
    logic               r_range_err;

    logic               w_s2_load;
    logic               w_s1_load;
    logic               w_accept;
    logic               w_range_bad;
    logic [Q_WIDTH-1:0] w_s2_c;

    // A stage may load when it is empty or its contents move on this edge.
    assign w_s2_load   = !r_vld_pipe[2] || out_ready;
    assign w_s1_load   = !r_vld_pipe[1] || w_s2_load;
    assign w_accept    = in_valid && w_s1_load;
    assign w_range_bad = (a >= Q) || (b >= Q);
    // On borrow the low bits already equal a - b + 2^30; adding Q wraps to a - b + Q.
    assign w_s2_c      = r_s1_diff[Q_WIDTH] ? (r_s1_diff[Q_WIDTH-1:0] + Q)
                                            : r_s1_diff[Q_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe[1] <= 1'b0;
            r_s1_diff     <= '0;
        end else if (w_s1_load) begin
            r_vld_pipe[1] <= w_accept;
            if (w_accept)
                r_s1_diff <= {1'b0, a} - {1'b0, b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe[2] <= 1'b0;
            r_s2_c        <= '0;
        end else if (w_s2_load) begin
            r_vld_pipe[2] <= r_vld_pipe[1];
            if (r_vld_pipe[1])
                r_s2_c <= w_s2_c;
        end
    end

    // A fresh violation outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_range_err <= 1'b0;
        else if (w_accept && w_range_bad)
            r_range_err <= 1'b1;
        else if (clear_err)
            r_range_err <= 1'b0;
    end

    assign in_ready  = w_s1_load;
    assign out_valid = r_vld_pipe[2];
    assign c         = r_s2_c;
    assign range_err = r_range_err;

endmodule
